// File: rtl/waterfall_pkg.sv
// rtl/waterfall_pkg.sv - shared constants, FSM encoding and address helper for the waterfall line writer
package waterfall_pkg;

    localparam int WF_COLS   = 80;
    localparam int WF_ROWS   = 60;
    localparam int WF_ADDR_W = 13;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        WAIT_BLANK = 2'd1,
        COPY       = 2'd2
    } wf_state_e;

    // Linear framebuffer address of pixel (col, row) for a row pitch of cols.
    function automatic logic [WF_ADDR_W-1:0] wf_addr(input int col, input int row, input int cols);
        return WF_ADDR_W'(col + row * cols);
    endfunction

endpackage

// File: rtl/waterfall_line_writer_line_buf.sv
// rtl/waterfall_line_writer_line_buf.sv - one-row pixel buffer, simple dual-port, 1-cycle read latency
module line_buf #(
    parameter int DEPTH = 80,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // No reset on the array or read register so the buffer maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/waterfall_line_writer.sv
// rtl/waterfall_line_writer.sv - builds one waterfall row from ADC samples and copies it to the framebuffer in vblank
// Optional feature: WATERFALL_AVG_EN selects group averaging instead of keep-last decimation.
module waterfall_line_writer
    import waterfall_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 12,
    parameter int DECIM_LOG2   = 2,
    parameter int COLS         = WF_COLS,
    parameter int ROWS         = WF_ROWS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    input  logic                    vblank,
    output logic [WF_ADDR_W-1:0]    ram_addr,
    output logic [7:0]              ram_wdata,
    output logic                    ram_we,
    output logic [5:0]              top_row,
    output logic                    busy,
    output logic                    dropped
);

    localparam int              CW       = $clog2(COLS + 1);
    localparam int              DW       = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [DW-1:0]   DEC_LAST = DW'((1 << DECIM_LOG2) - 1);
    localparam logic [CW-1:0]   COL_LAST = CW'(COLS - 1);
    localparam logic [CW-1:0]   COPY_END = CW'(COLS);
    localparam logic [5:0]      ROW_LAST = 6'(ROWS - 1);

    wf_state_e             state_q, state_d;
    logic [5:0]            write_row_q, write_row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [DW-1:0]         dec_q, dec_d;
    logic                  vblank_q;
    logic                  ram_we_q, ram_we_d;
    logic [WF_ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [5:0]            top_row_q, top_row_d;
    logic                  dropped_q, dropped_d;

    logic                  group_done;
    logic [7:0]            pixel;
    logic                  lb_we;
    logic [CW-1:0]         lb_raddr;
    logic [7:0]            lb_rdata;

    assign group_done = (dec_q == DEC_LAST);

`ifdef WATERFALL_AVG_EN
    localparam int ACC_W = SAMPLE_WIDTH + DECIM_LOG2;

    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;

    assign acc_sum = acc_q + ACC_W'(sample_data);
    assign pixel   = acc_sum[ACC_W-1 -: 8];

    // Only advances in FILL; it is cleared at every group end, so it is already 0 when FILL resumes.
    always_comb begin
        acc_d = acc_q;
        if (state_q == FILL && sample_valid) begin
            acc_d = group_done ? '0 : acc_sum;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic unused_sample_lsbs;

    assign pixel              = sample_data[SAMPLE_WIDTH-1 -: 8];
    assign unused_sample_lsbs = ^sample_data[SAMPLE_WIDTH-9:0];
`endif

    // col is the FILL write column and doubles as the COPY read index (0..COLS, COLS = drain cycle).
    always_comb begin
        state_d     = state_q;
        write_row_d = write_row_q;
        col_d       = col_q;
        dec_d       = dec_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        top_row_d   = top_row_q;
        dropped_d   = sample_valid && (state_q != FILL);
        lb_we       = 1'b0;
        unique case (state_q)
            FILL: begin
                if (sample_valid) begin
                    dec_d = group_done ? '0 : dec_q + DW'(1);
                    if (group_done) begin
                        lb_we = 1'b1;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            state_d = WAIT_BLANK;
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end
            end
            WAIT_BLANK: begin
                if (vblank && !vblank_q) begin
                    state_d = COPY;
                end
            end
            COPY: begin
                if (col_q == COPY_END) begin
                    col_d       = '0;
                    state_d     = FILL;
                    top_row_d   = write_row_q;
                    write_row_d = (write_row_q == ROW_LAST) ? 6'd0 : write_row_q + 6'd1;
                end else begin
                    col_d      = col_q + CW'(1);
                    ram_we_d   = 1'b1;
                    ram_addr_d = wf_addr(int'(col_q), int'(write_row_q), COLS);
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            write_row_q <= '0;
            col_q       <= '0;
            dec_q       <= '0;
            vblank_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            top_row_q   <= '0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_row_q <= write_row_d;
            col_q       <= col_d;
            dec_q       <= dec_d;
            vblank_q    <= vblank;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            top_row_q   <= top_row_d;
            dropped_q   <= dropped_d;
        end
    end

    assign lb_raddr = (col_q < COPY_END) ? col_q : '0;

    line_buf #(
        .DEPTH (COLS),
        .AW    (CW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (col_q),
        .wr_data (pixel),
        .rd_addr (lb_raddr),
        .rd_data (lb_rdata)
    );

    // Read data lines up with the registered write strobe; gated so the bus idles at 0.
    assign ram_wdata = ram_we_q ? lb_rdata : 8'h00;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign top_row   = top_row_q;
    assign busy      = (state_q != FILL);
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_waterfall_line_writer.sv
// tb/tb_waterfall_line_writer.sv - self-checking bench for waterfall_line_writer with a row-level reference model
module tb_waterfall_line_writer;

    localparam int SW   = 12;
    localparam int DL   = 2;
    localparam int GS   = 1 << DL;
    localparam int COLS = 80;
    localparam int ROWS = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic        vblank;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [5:0]  top_row;
    logic        busy;
    logic        dropped;

    always #5 clk = ~clk;

    waterfall_line_writer #(
        .SAMPLE_WIDTH (SW),
        .DECIM_LOG2   (DL),
        .COLS         (COLS),
        .ROWS         (ROWS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .vblank       (vblank),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .top_row      (top_row),
        .busy         (busy),
        .dropped      (dropped)
    );

    typedef struct packed {
        logic [11:0] s0;
        logic [11:0] s1;
        logic [11:0] s2;
        logic [11:0] s3;
        logic [7:0]  exp_dec;
        logic [7:0]  exp_avg;
    } vec_t;

    vec_t vt [6];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   drop_cnt = 0;
    int   tr_cyc = -1;
    logic [5:0] tr_prev = 6'd0;
    int   wq_addr [$];
    int   wq_data [$];
    int   wq_cyc [$];
    bit   wrote [ROWS*COLS];
    int   exp_pix [COLS];
    int   exp_row = 0;
    int   last_top = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, then observe outputs at the falling edge as a RAM/observer would.
    task automatic cycle(input logic v, input logic [11:0] d, input logic vb);
        int a;
        sample_valid = v;
        sample_data  = d;
        vblank       = vb;
        @(negedge clk);
        cyc++;
        if (ram_we) begin
            a = int'(ram_addr);
            wq_addr.push_back(a);
            wq_data.push_back(int'(ram_wdata));
            wq_cyc.push_back(cyc);
            if (a < ROWS*COLS) wrote[a] = 1'b1;
        end
        if (dropped) drop_cnt++;
        if (top_row != tr_prev) begin
            tr_cyc  = cyc;
            tr_prev = top_row;
        end
    endtask

    function automatic int ref_pixel(input int s [GS]);
        int sum = 0;
`ifdef WATERFALL_AVG_EN
        foreach (s[i]) sum += s[i];
        return (sum >> (SW + DL - 8)) & 255;
`else
        sum = s[GS-1];
        return (sum >> (SW - 8)) & 255;
`endif
    endfunction

    function automatic logic [11:0] pick(input vec_t v, input int k);
        case (k)
            0:       return v.s0;
            1:       return v.s1;
            2:       return v.s2;
            default: return v.s3;
        endcase
    endfunction

    function automatic int table_exp(input vec_t v);
`ifdef WATERFALL_AVG_EN
        return int'(v.exp_avg);
`else
        return int'(v.exp_dec);
`endif
    endfunction

    // mode 0: ramp (pixel c from samples c<<4), 1: table vectors, 2: random with idle gaps
    task automatic fill_row(input int mode, input logic vb);
        logic [11:0] g [GS];
        int          s [GS];
        for (int c = 0; c < COLS; c++) begin
            for (int k = 0; k < GS; k++) begin
                case (mode)
                    0:       g[k] = 12'(c << 4);
                    1:       g[k] = pick(vt[c % 6], k);
                    default: g[k] = 12'($urandom_range(0, 4095));
                endcase
                s[k] = int'(g[k]);
            end
            if (mode == 0)      exp_pix[c] = c;
            else if (mode == 1) exp_pix[c] = table_exp(vt[c % 6]);
            else                exp_pix[c] = ref_pixel(s);
            for (int k = 0; k < GS; k++) begin
                if (mode == 2) begin
                    repeat ($urandom_range(0, 1)) cycle(1'b0, 12'($urandom_range(0, 4095)), vb);
                end
                cycle(1'b1, g[k], vb);
            end
        end
    endtask

    // Raise vblank, collect the row copy and compare it with exp_pix/exp_row.
    task automatic copy_row(input int abort_at, input int n_drop);
        int  r;
        int  base;
        int  n;
        int  d0;
        int  bad;
        bit  aborted;
        aborted = 1'b0;
        base = exp_row * COLS;
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        tr_cyc = -1;
        cycle(1'b0, 12'h000, 1'b0);
        d0 = drop_cnt;
        r  = cyc + 1;
        for (int k = 0; k < 130; k++) begin
            cycle(k < n_drop, 12'($urandom_range(0, 4095)), 1'b1);
            if (abort_at >= 0 && wq_addr.size() == abort_at) begin
                reset = 1'b1;
                #1;
                check("reset_we_immediate", int'(ram_we), 0);
                check("reset_busy_immediate", int'(busy), 0);
                cycle(1'b0, 12'h000, 1'b0);
                cycle(1'b0, 12'h000, 1'b0);
                reset = 1'b0;
                cycle(1'b0, 12'h000, 1'b0);
                aborted = 1'b1;
                break;
            end
        end
        n = (wq_addr.size() < COLS) ? wq_addr.size() : COLS;
        for (int i = 0; i < n; i++) begin
            check($sformatf("row%0d_addr%0d", exp_row, i), wq_addr[i], base + i);
            check($sformatf("row%0d_data%0d", exp_row, i), wq_data[i], exp_pix[i]);
        end
        if (aborted) begin
            check("abort_write_count", wq_addr.size(), abort_at);
            bad = 0;
            for (int i = abort_at; i < COLS; i++) bad += int'(wrote[base + i]);
            check("abort_tail_unwritten", bad, 0);
            check("reset_top_row", int'(top_row), 0);
            exp_row  = 0;
            last_top = 0;
        end else begin
            check("write_count", wq_addr.size(), COLS);
            if (n > 0) begin
                // vblank is high from cycle r-1 (sampled at its closing edge); first write 2 cycles later.
                check("first_we_latency", wq_cyc[0] - (r - 1), 2);
                check("we_consecutive", wq_cyc[n-1] - wq_cyc[0], n - 1);
                if (exp_row != last_top) begin
                    check("top_row_timing", tr_cyc, wq_cyc[n-1] + 1);
                end
            end
            check("top_row", int'(top_row), exp_row);
            check("busy_after_copy", int'(busy), 0);
            check("copy_drops", drop_cnt - d0, n_drop);
            last_top = exp_row;
            exp_row  = (exp_row + 1) % ROWS;
        end
        cycle(1'b0, 12'h000, 1'b0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int n0;
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_data  = 12'h000;
        vblank       = 1'b0;

        vt[0] = '{12'hFF0, 12'hFF0, 12'h000, 12'h000, 8'h00, 8'h7F};
        vt[1] = '{12'h000, 12'h000, 12'h000, 12'hFFF, 8'hFF, 8'h3F};
        vt[2] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 8'hFF, 8'hFF};
        vt[3] = '{12'h123, 12'h456, 12'h789, 12'hABC, 8'hAB, 8'h5E};
        vt[4] = '{12'h800, 12'h7FF, 12'h000, 12'h010, 8'h01, 8'h40};
        vt[5] = '{12'h080, 12'h080, 12'h080, 12'h080, 8'h08, 8'h08};

        repeat (3) cycle(1'b0, 12'h000, 1'b0);
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_wdata", int'(ram_wdata), 0);
        check("rst_top_row", int'(top_row), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dropped", int'(dropped), 0);
        reset = 1'b0;
        cycle(1'b0, 12'h000, 1'b0);

        // Row 0: ramp; row 1: table vectors with drops during COPY.
        fill_row(0, 1'b0);
        copy_row(-1, 0);
        fill_row(1, 1'b0);
        copy_row(-1, 10);

        // Row 2: strobes while waiting for blanking are dropped and leave the buffer untouched.
        fill_row(2, 1'b0);
        check("wait_busy", int'(busy), 1);
        d0 = drop_cnt;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 12'($urandom_range(0, 4095)), 1'b0);
            cycle(1'b0, 12'h000, 1'b0);
        end
        check("wait_drops", drop_cnt - d0, 5);
        copy_row(-1, 0);

        // Row 3: first sample after COPY must land in col 0.
        fill_row(0, 1'b0);
        copy_row(-1, 0);

        // Row 4: completes with vblank already high; nothing is written until the next rise.
        n0 = wq_addr.size();
        fill_row(2, 1'b1);
        repeat (100) cycle(1'b0, 12'h000, 1'b1);
        check("late_no_we", wq_addr.size(), n0);
        check("late_busy", int'(busy), 1);
        copy_row(-1, 0);

        // Rows 5..60: random rows; row 60 wraps to base 0.
        for (int r = 5; r <= 60; r++) begin
            fill_row(2, 1'b0);
            copy_row(-1, $urandom_range(0, 3));
        end

        // Reset at the 40th write of row 1, then the next row restarts at base 0.
        foreach (wrote[i]) wrote[i] = 1'b0;
        fill_row(2, 1'b0);
        copy_row(40, 0);
        fill_row(0, 1'b0);
        copy_row(-1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/waterfall_line_writer.md
# waterfall_line_writer

Converts the ADC sample stream into one 80-pixel waterfall row at a time and writes each completed row into the 80×60×8-bit framebuffer RAM during vertical blanking. It sits between `adc` (upstream, `ready`/`data`) and the shared framebuffer RAM that the LCD driver reads. It replaces the top level's fixed reset-time fill. It also publishes the most recently written row so the display can scroll.

## Interface
- `SAMPLE_WIDTH`, 12, ADC sample width in bits.
- `DECIM_LOG2`, 2, log2 of ADC samples per pixel; 0 means one sample per pixel.
- `COLS`, 80, pixels per row.
- `ROWS`, 60, rows in the framebuffer.
- `clk` input 1: pixel clock; one clock domain.
- `reset` input 1: asynchronous, active-high.
- `sample_valid` input 1: one-cycle strobe from `adc.ready`.
- `sample_data` input SAMPLE_WIDTH: ADC sample, valid with the strobe.
- `vblank` input 1: level, high during the lower blanking interval.
- `ram_addr` output 13: framebuffer write address, `col + row*COLS`.
- `ram_wdata` output 8: pixel intensity.
- `ram_we` output 1: write enable. The top level muxes `ram_addr` onto the RAM when this is high.
- `top_row` output 6: row written last.
- `busy` output 1: high in WAIT_BLANK or COPY.
- `dropped` output 1: one-cycle pulse for each discarded sample.

## Operation
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `top_row`=0, `busy`=0, `dropped`=0. Internal state: state=FILL, `write_row`=0, `col`=0, decimation count=0, accumulator=0, `vblank_d`=0.
- Pixel formation happens in FILL. On each `sample_valid` the decimation counter increments. The pixel is produced when the counter reaches 2^DECIM_LOG2−1; the counter then wraps to 0.
  - The pixel is stored to the line buffer at `col`, and `col` increments.
  - How the pixel value is formed depends on the configuration macro (see Configuration).
- When the pixel at `col`=COLS−1 is stored, the state moves to WAIT_BLANK and `col` returns to 0.
- WAIT_BLANK: waits for a vblank rising edge (`vblank`=1 and `vblank_d`=0), then enters COPY.
  - A row that completes while `vblank` is already high waits for the next rising edge.
- COPY reads the line buffer at index i and writes RAM in the following cycle.
  - RAM writes use `ram_addr = i + write_row*COLS`, for i = 0..COLS−1.
  - `ram_we` is high for exactly COLS consecutive cycles.
- COPY completion:
  - `top_row` ← `write_row`.
  - `write_row` ← `write_row`+1, wrapping from ROWS−1 to 0.
  - `ram_we` ← 0, and the state returns to FILL.
- Samples arriving in WAIT_BLANK or COPY are discarded, and `dropped` pulses for each one. The decimation count and accumulator stay at 0, so FILL always starts a fresh pixel group at col 0.
- Asserting `reset` at any time, including mid-COPY, immediately forces all reset values. A partially written row is left as-is in RAM.

## Timing
- Latency from the vblank rising edge (sampled at edge n) to the first `ram_we`: 2 cycles (COPY entry, then one cycle of line-buffer read latency).
- COPY occupies COLS+1 cycles. It must end before `vblank` falls; this holds for any blanking interval of at least one line.
- `dropped` asserts in the cycle after the discarded strobe.
- `top_row` updates in the cycle after the last `ram_we`.

## Configuration
- `WATERFALL_AVG_EN` defined (averaging):
  - An accumulator of width SAMPLE_WIDTH+DECIM_LOG2 sums all 2^DECIM_LOG2 samples in a group.
  - Pixel = accumulator top 8 bits, i.e. `acc[SAMPLE_WIDTH+DECIM_LOG2-1 -: 8]`. The accumulator clears after each pixel.
- `WATERFALL_AVG_EN` undefined (decimation):
  - Pixel = `sample_data[SAMPLE_WIDTH-1 -: 8]` of the last sample in each group; the other samples are ignored.
  - No accumulator is instantiated.

## Structure
- Shared package `waterfall_pkg`:
  - constants `WF_COLS`=80, `WF_ROWS`=60, `WF_ADDR_W`=13;
  - state enum FILL/WAIT_BLANK/COPY.
- Sub-module `line_buf`: COLS×8 simple dual-port RAM with a synchronous write port, a synchronous read port and 1-cycle read latency, which infers as BRAM.

## Test plan
- Ramp, DECIM_LOG2=0, macro undefined: samples `k<<4` for k=0..79, then a vblank rise → writes addr 0..79 with data 0..79 on COLS consecutive cycles, then `top_row`=0 and next row base 80.
- Averaging, DECIM_LOG2=2, macro defined: group 0xFF0, 0xFF0, 0x000, 0x000 → pixel 0x7F. Same group with the macro undefined → pixel 0x00.
- Row wrap: fill 61 rows → row 60 writes addr 0..79 again, and `top_row` sequence ends …,59,0.
- Drops: 5 strobes during WAIT_BLANK → 5 `dropped` pulses and no line-buffer change. The first FILL sample after COPY lands in col 0.
- Late completion: the row completes with `vblank` already high → no `ram_we` until the next vblank rising edge.
- Reset at the 40th `ram_we` of COPY → `ram_we`=0 immediately. Addr 40..79 of that row are not written. The next row writes base 0, and `top_row`=0.
